scalar_writeback_unit: RTL
==========================

SCALAR_WRITEBACK_UNIT -- requirements
Module: scalar_writeback_unit

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 32, data width.
REQ-002 SHALL have parameter ADDR_NUMBER, default 5, register address width.
REQ-003 SHALL have parameter REGISTER_NUMBER, default 16, number of implemented scalar registers.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, writeback queue entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have ports alu_valid input 1, alu_ready output 1, alu_dest input ADDR_NUMBER, alu_data input BIT_NUMBER: ALU writeback request channel.
REQ-008 SHALL have ports mem_valid input 1, mem_ready output 1, mem_dest input ADDR_NUMBER, mem_data input BIT_NUMBER: load writeback request channel.
REQ-009 SHALL have port wb_hold  input  1  when high, register-file write port unavailable; queue does not drain.
REQ-010 SHALL have ports rf_write_enable output 1, rf_dest_addr output ADDR_NUMBER, rf_write_data output BIT_NUMBER: registered drive of the scalar register file write port.
REQ-011 SHALL have port pending_mask  output  REGISTER_NUMBER  bit r high while any accepted, unwritten request targets register r.
REQ-012 SHALL have port addr_error  output  1  one-cycle pulse when an out-of-range request is accepted.

Function
REQ-013 SHALL transfer a request on a channel at a posedge where its valid and ready are both high.
REQ-014 SHALL accept at most one request per cycle.
REQ-015 SHALL drive a channel's ready high only when queue count < FIFO_DEPTH and the arbiter grants that channel; ready may depend combinationally on both valids.
REQ-016 SHALL grant the sole valid channel when only one is valid; when both valid, grant the channel not granted at the last two-way contention (round-robin, one-bit last_grant register).
REQ-017 SHALL update last_grant only on cycles where both channels are valid and a transfer occurs.
REQ-018 SHALL enqueue an accepted request {dest, data} at the queue tail, preserving acceptance order.
REQ-019 SHALL, for an accepted request with dest >= REGISTER_NUMBER, not enqueue it, not touch pending_mask, and pulse addr_error high in the next cycle.
REQ-020 SHALL pop the queue head at each posedge where count > 0 and wb_hold is low, registering rf_write_enable=1, rf_dest_addr=head dest, rf_write_data=head data for the following cycle.
REQ-021 SHALL register rf_write_enable=0 at every posedge with no pop; rf_dest_addr and rf_write_data hold their last values.
REQ-022 SHALL support push and pop at the same posedge; count unchanged; full queue does not admit a same-cycle push (ready uses pre-pop count).
REQ-023 SHALL give one-request latency: request accepted at edge N into an empty queue with wb_hold low pops at edge N+1; rf_write_enable high during cycle after edge N+1.
REQ-024 SHALL keep a per-register outstanding counter of width clog2(FIFO_DEPTH+1); increment on enqueue, decrement on pop; both at once leaves it unchanged; pending_mask[r] = (counter r != 0).
REQ-025 SHALL wrap queue read/write pointers modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, at a posedge with reset high, empty the queue, clear all counters, set last_grant to mem (alu wins the first contention), and drive rf_write_enable=0, rf_dest_addr=0, rf_write_data=0, addr_error=0.
REQ-027 SHALL discard in-flight queue contents and ignore requests presented in a reset cycle; alu_ready and mem_ready SHALL be low while reset is high.

Verification
REQ-028 Single ALU request dest=3 data=0xDEADBEEF, wb_hold=0 -> pending_mask[3]=1 after accept; rf_write_enable=1, rf_dest_addr=3, rf_write_data=0xDEADBEEF one cycle later; pending_mask[3]=0 thereafter.
REQ-029 Both channels valid for 4 cycles, wb_hold=1 -> grants alu,mem,alu,mem; 5th cycle both readys low (full); release wb_hold -> four writes in that order on consecutive cycles.
REQ-030 Two requests to dest=5 queued (wb_hold=1), then drain -> pending_mask[5] stays 1 after first write, drops to 0 only after second write.
REQ-031 mem request dest=20 (REGISTER_NUMBER=16) -> mem_ready=1, addr_error pulses one cycle, no rf_write_enable, pending_mask unchanged.
REQ-032 Full queue with simultaneous pop and valid request -> request not accepted that cycle, accepted next cycle; FIFO order intact across pointer wrap.
REQ-033 Reset asserted with 3 queued entries -> next cycle rf_write_enable=0, pending_mask=0, queue empty; post-reset contention grants alu first.

Source files
------------

// File: rtl/scalar_writeback_unit.sv
// Scalar register-file writeback unit: arbitrates ALU and load results into an
// in-order queue, drains one entry per cycle to the RF write port, and tracks pending registers.
module scalar_writeback_unit #(
  parameter int BIT_NUMBER      = 32,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_NUMBER-1:0]     alu_dest,
  input  logic [BIT_NUMBER-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_NUMBER-1:0]     mem_dest,
  input  logic [BIT_NUMBER-1:0]      mem_data,
  input  logic                       wb_hold,
  output logic                       rf_write_enable,
  output logic [ADDR_NUMBER-1:0]     rf_dest_addr,
  output logic [BIT_NUMBER-1:0]      rf_write_data,
  output logic [REGISTER_NUMBER-1:0] pending_mask,
  output logic                       addr_error
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [ADDR_NUMBER-1:0] q_dest [FIFO_DEPTH];
  logic [BIT_NUMBER-1:0]  q_data [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          outstanding [REGISTER_NUMBER];
  logic                   last_grant_mem;

  logic                   grant_alu;
  logic                   grant_mem;
  logic                   not_full;
  logic                   accept;
  logic                   in_range;
  logic                   push;
  logic                   pop;
  logic [ADDR_NUMBER-1:0] sel_dest;
  logic [BIT_NUMBER-1:0]  sel_data;
  logic [ADDR_NUMBER-1:0] head_dest;
  logic [REGISTER_NUMBER-1:0] inc_vec;
  logic [REGISTER_NUMBER-1:0] dec_vec;

  // Arbitration and acceptance: ready uses the pre-pop count, so a full queue
  // never admits a same-cycle push even while it drains.
  always_comb begin
    grant_alu = alu_valid && (!mem_valid || last_grant_mem);
    grant_mem = mem_valid && (!alu_valid || !last_grant_mem);
    not_full  = (count < DEPTH_C);
    alu_ready = !reset && not_full && grant_alu;
    mem_ready = !reset && not_full && grant_mem;
    accept    = alu_ready || mem_ready;
    sel_dest  = grant_alu ? alu_dest : mem_dest;
    sel_data  = grant_alu ? alu_data : mem_data;
    in_range  = (int'(sel_dest) < REGISTER_NUMBER);
    push      = accept && in_range;
    pop       = !reset && (count != '0) && !wb_hold;
    head_dest = q_dest[rd_ptr];
  end

  always_comb begin
    inc_vec      = '0;
    dec_vec      = '0;
    pending_mask = '0;
    for (int r = 0; r < REGISTER_NUMBER; r++) begin
      inc_vec[r]      = push && (int'(sel_dest) == r);
      dec_vec[r]      = pop && (int'(head_dest) == r);
      pending_mask[r] = (outstanding[r] != '0);
    end
  end

  // Queue storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_dest[wr_ptr] <= sel_dest;
      q_data[wr_ptr] <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      last_grant_mem  <= 1'b1;
      rf_write_enable <= 1'b0;
      rf_dest_addr    <= '0;
      rf_write_data   <= '0;
      addr_error      <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Round-robin state only moves on an actual two-way contention.
      if (alu_valid && mem_valid && accept)
        last_grant_mem <= grant_mem;
      addr_error      <= accept && !in_range;
      rf_write_enable <= pop;
      if (pop) begin
        rf_dest_addr  <= head_dest;
        rf_write_data <= q_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < REGISTER_NUMBER; r++) begin
      if (reset)
        outstanding[r] <= '0;
      else if (inc_vec[r] && !dec_vec[r])
        outstanding[r] <= outstanding[r] + CW'(1);
      else if (dec_vec[r] && !inc_vec[r])
        outstanding[r] <= outstanding[r] - CW'(1);
    end
  end

endmodule
